i2c_target_regfile: RTL and testbench
=====================================

# i2c_target_regfile

I2C target (slave) with an internal register file. It is the bus-side consumer of `i2c_controller` transactions: it decodes START/STOP, matches a 7-bit address, accepts a register pointer and write data, and serves read data with auto-increment. It sits on the same open-drain SDA/SCL pair as the controller and exposes bus writes and register contents to local logic.

## Interface
- `TARGET_ADDR`, default 7'h50: 7-bit bus address the block ACKs.
- `NUM_REGS`, default 16: register count; power of two, 2..256.
- `i2c_clk`  in  1  oversampling clock; must be at least 8× the SCL frequency.
- `rst`  in  1  reset, asynchronous, active-low.
- `scl_in`  in  1  raw SCL pad input (asynchronous).
- `sda_in`  in  1  raw SDA pad input (asynchronous).
- `sda_oe`  out  1  1 pulls SDA low; the pad drives 1'bz otherwise. The block never drives SCL.
- `wr_valid`  out  1  one-cycle pulse per bus-written data byte.
- `wr_addr`  out  log2(NUM_REGS)  register index of the write.
- `wr_data`  out  8  byte written.
- `reg_addr`  in  log2(NUM_REGS)  local read index.
- `reg_rdata`  out  8  combinational `regs[reg_addr]`.
- `busy`  out  1  high from address match until STOP or a repeated START.

## Operation
- Input conditioning: 2-FF synchronizer on SCL and SDA, plus one history flop for edge detect.
  - `scl_rise`, `scl_fall`: SCL edges.
  - `start`: SDA falls while SCL is high.
  - `stop`: SDA rises while SCL is high.
- Bus data is sampled on `scl_rise`. `sda_oe` changes only on `scl_fall`, except that it clears immediately on `stop`, `start` or reset.
- FSM states: IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WDATA, WDATA_ACK, RDATA, RDATA_ACK, WAIT_STOP.
- Global transitions:
  - `start` from any state goes to ADDR, clears the bit counter and leaves the pointer unchanged.
  - `stop` from any state goes to IDLE and clears `busy`.
  - `start` and `stop` cannot occur in the same cycle.
- ADDR: shifts 8 bits, MSB first.
  - On the 8th bit, if addr[7:1] == TARGET_ADDR, go to ADDR_ACK and set `busy`.
  - Otherwise go to WAIT_STOP with no ACK.
- ADDR_ACK: drive ACK. After the ACK clock falls, go to RDATA if the R/W bit is 1, or to PTR if it is 0.
- PTR: shift 8 bits. The pointer loads byte mod NUM_REGS. Then go to PTR_ACK, then WDATA.
- WDATA: shift 8 bits.
  - Write `regs[ptr]`.
  - Pulse `wr_valid` with `wr_addr` = ptr and `wr_data` = byte on the cycle after the 8th `scl_rise`.
  - Increment ptr, wrapping NUM_REGS-1 → 0.
  - Then go to WDATA_ACK (always ACK), then WDATA.
- RDATA:
  - Load the shift register from `regs[ptr]` on entry, i.e. on the ACK-slot `scl_fall`.
  - Drive bits MSB first: `sda_oe` = ~bit.
  - After the 8th bit's `scl_fall`, release SDA, increment ptr (with wrap) and go to RDATA_ACK.
- RDATA_ACK: sample the controller's ACK on `scl_rise`.
  - SDA = 0: return to RDATA.
  - SDA = 1 (NACK): go to WAIT_STOP.
- WAIT_STOP: `sda_oe` = 0. Ignore everything except `start` and `stop`.
- ACK drive: `sda_oe` = 1 from the `scl_fall` that ends bit 8 to the next `scl_fall`.
- Reset values:
  - `sda_oe`, `wr_valid`, `busy` = 0.
  - `wr_addr`, `wr_data` = 0.
  - All regs and ptr = 0.
  - State = IDLE.
- Reset mid-transfer releases SDA asynchronously. Any bus activity before the next `start` is ignored.

## Timing
- Pad-to-event latency: 3 `i2c_clk` cycles (2 sync stages + edge compare). Events are single-cycle pulses.
- `sda_oe` updates 1 cycle after `scl_fall` is detected, i.e. ≤4 cycles after the pad edge. This is well within SCL low time at the 8× ratio.
- `wr_valid` is asserted exactly 1 cycle after the 8th-bit `scl_rise` pulse.
- The regfile write and ptr increment happen in that same cycle.
- `reg_rdata` has zero-cycle latency and reflects a write in the cycle after `wr_valid`.
- Local reads and bus writes to the same index: the local read returns the old value until the write cycle completes.

## Structure
- Shared package `i2c_pkg`: FSM state enum, `I2C_ACK` = 1'b0, `I2C_NACK` = 1'b1, bit-counter width constant.
- Sub-module `i2c_bus_sync`: synchronizers plus the `scl_rise`/`scl_fall`/`start`/`stop` detector. The top level contains the FSM, shift register, pointer and regfile.

## Test plan
- Write 0xA0 (addr 0x50, W), 0x03, 0x11, 0x22, STOP
  - ACK on all 4 bytes.
  - `wr_valid` ×2 with (3, 0x11) then (4, 0x22).
  - `reg_rdata`@3 = 0x11.
- Write ptr 0x05 with no data, repeated START, 0xA1, read 3 bytes ACK/ACK/NACK, STOP, with regs 5..7 = 0x5A, 0x00, 0xFF
  - Returns 0x5A, 0x00, 0xFF.
  - SDA released after the NACK.
  - `busy` drops at STOP.
- Address 0xA2 (0x51)
  - No ACK; `sda_oe` stays 0 through 9 clocks.
  - The following STOP returns the FSM to IDLE.
- NUM_REGS = 16: ptr 0x0F, write 0xAB, 0xCD
  - Writes land at indexes 15 then 0.
  - A ptr byte of 0x13 loads ptr = 3.
- STOP mid-byte (after 4 bits of data)
  - No `wr_valid`, regs unchanged, state IDLE.
- Assert `rst` low during a read bit driving 0
  - `sda_oe` goes to 0 within the same cycle.
  - All outputs return to reset values.

Source files
------------

// File: rtl/i2c_pkg.sv
// Shared definitions for the I2C target register file.
//   i2c_state_e   : target FSM state encoding
//   I2C_ACK/NACK  : SDA level of the acknowledge bit
//   BIT_CNT_W     : width of the per-byte bit counter
package i2c_pkg;

  typedef enum logic [3:0] {
    IDLE,
    ADDR,
    ADDR_ACK,
    PTR,
    PTR_ACK,
    WDATA,
    WDATA_ACK,
    RDATA,
    RDATA_ACK,
    WAIT_STOP
  } i2c_state_e;

  localparam logic I2C_ACK  = 1'b0;
  localparam logic I2C_NACK = 1'b1;

  localparam int unsigned BIT_CNT_W = 4;
  localparam logic [BIT_CNT_W-1:0] LAST_BIT  = BIT_CNT_W'(7);
  localparam logic [BIT_CNT_W-1:0] BYTE_BITS = BIT_CNT_W'(8);

endpackage

// File: rtl/i2c_target_regfile_if.sv
// Bus and local-access signals of the I2C target register file.
//   scl_in, sda_in : raw pad inputs (asynchronous)
//   sda_oe         : 1 pulls SDA low
//   wr_valid/wr_addr/wr_data : bus-write notification
//   reg_addr/reg_rdata       : local combinational read port
//   busy           : addressed transfer in progress
interface i2c_target_regfile_if #(
  parameter int unsigned AW = 4
);
  logic          scl_in;
  logic          sda_in;
  logic          sda_oe;
  logic          wr_valid;
  logic [AW-1:0] wr_addr;
  logic [7:0]    wr_data;
  logic [AW-1:0] reg_addr;
  logic [7:0]    reg_rdata;
  logic          busy;

  modport slave (
    input  scl_in, sda_in, reg_addr,
    output sda_oe, wr_valid, wr_addr, wr_data, reg_rdata, busy
  );

  modport master (
    output scl_in, sda_in, reg_addr,
    input  sda_oe, wr_valid, wr_addr, wr_data, reg_rdata, busy
  );
endinterface

// File: rtl/i2c_bus_sync.sv
// Pad conditioning: 2-FF synchronizers on SCL/SDA plus one history flop,
// producing single-cycle SCL edge and START/STOP pulses.
//   i2c_clk, rst : oversampling clock, async active-low reset
//   scl_i, sda_i : raw pad inputs
//   sda_o        : synchronized SDA level
//   scl_rise_o, scl_fall_o, start_o, stop_o : event pulses
module i2c_bus_sync (
  input  logic i2c_clk,
  input  logic rst,
  input  logic scl_i,
  input  logic sda_i,
  output logic sda_o,
  output logic scl_rise_o,
  output logic scl_fall_o,
  output logic start_o,
  output logic stop_o
);

  logic scl_s1_q, scl_s2_q, scl_h_q;
  logic sda_s1_q, sda_s2_q, sda_h_q;

  // Idle bus is high, so reset to 1 to avoid a spurious edge at release.
  always_ff @(posedge i2c_clk or negedge rst) begin
    if (!rst) begin
      scl_s1_q <= 1'b1;
      scl_s2_q <= 1'b1;
      scl_h_q  <= 1'b1;
      sda_s1_q <= 1'b1;
      sda_s2_q <= 1'b1;
      sda_h_q  <= 1'b1;
    end else begin
      scl_s1_q <= scl_i;
      scl_s2_q <= scl_s1_q;
      scl_h_q  <= scl_s2_q;
      sda_s1_q <= sda_i;
      sda_s2_q <= sda_s1_q;
      sda_h_q  <= sda_s2_q;
    end
  end

  assign sda_o      = sda_s2_q;
  assign scl_rise_o = scl_s2_q & ~scl_h_q;
  assign scl_fall_o = ~scl_s2_q & scl_h_q;
  // SDA transitions only count as START/STOP while SCL is stably high.
  assign start_o    = scl_s2_q & scl_h_q & sda_h_q & ~sda_s2_q;
  assign stop_o     = scl_s2_q & scl_h_q & ~sda_h_q & sda_s2_q;

endmodule

// File: rtl/i2c_target_regfile.sv
// I2C target with an internal register file: address match, register
// pointer, auto-incrementing writes and reads, local write notification
// and a combinational local read port.
//   i2c_clk : oversampling clock (>= 8x SCL)
//   rst     : asynchronous active-low reset
//   bus     : slave modport carrying pads, write notification, local read
module i2c_target_regfile
  import i2c_pkg::*;
#(
  parameter logic [6:0]  TARGET_ADDR = 7'h50,
  parameter int unsigned NUM_REGS    = 16
) (
  input  logic                 i2c_clk,
  input  logic                 rst,
  i2c_target_regfile_if.slave  bus
);

  localparam int unsigned AW = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

  logic sda_s, scl_rise, scl_fall, start, stop;

  i2c_bus_sync u_sync (
    .i2c_clk    (i2c_clk),
    .rst        (rst),
    .scl_i      (bus.scl_in),
    .sda_i      (bus.sda_in),
    .sda_o      (sda_s),
    .scl_rise_o (scl_rise),
    .scl_fall_o (scl_fall),
    .start_o    (start),
    .stop_o     (stop)
  );

  i2c_state_e                 state_q;
  logic [BIT_CNT_W-1:0]       bitcnt_q;
  logic [7:0]                 shreg_q;
  logic [AW-1:0]              ptr_q;
  logic                       rw_q;
  logic                       sda_oe_q;
  logic                       wr_valid_q;
  logic [AW-1:0]              wr_addr_q;
  logic [7:0]                 wr_data_q;
  logic                       busy_q;
  logic [NUM_REGS-1:0][7:0]   regs_q;

  logic [7:0] shift_d;
  logic [7:0] rd_byte;

  assign shift_d = {shreg_q[6:0], sda_s};
  assign rd_byte = regs_q[ptr_q];

  always_ff @(posedge i2c_clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      bitcnt_q   <= '0;
      shreg_q    <= '0;
      ptr_q      <= '0;
      rw_q       <= 1'b0;
      sda_oe_q   <= 1'b0;
      wr_valid_q <= 1'b0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
      busy_q     <= 1'b0;
      regs_q     <= '0;
    end else begin
      wr_valid_q <= 1'b0;
      // Commit happens during the wr_valid cycle so local reads see the
      // old value until that cycle ends.
      if (wr_valid_q) begin
        regs_q[wr_addr_q] <= wr_data_q;
        ptr_q             <= ptr_q + 1'b1;
      end

      if (start) begin
        state_q  <= ADDR;
        bitcnt_q <= '0;
        sda_oe_q <= 1'b0;
        busy_q   <= 1'b0;
      end else if (stop) begin
        state_q  <= IDLE;
        sda_oe_q <= 1'b0;
        busy_q   <= 1'b0;
      end else begin
        case (state_q)
          IDLE, WAIT_STOP: ;

          ADDR: if (scl_rise) begin
            shreg_q <= shift_d;
            if (bitcnt_q == LAST_BIT) begin
              bitcnt_q <= '0;
              if (shift_d[7:1] == TARGET_ADDR) begin
                state_q <= ADDR_ACK;
                busy_q  <= 1'b1;
                rw_q    <= shift_d[0];
              end else begin
                state_q <= WAIT_STOP;
              end
            end else begin
              bitcnt_q <= bitcnt_q + 1'b1;
            end
          end

          // ACK slot: sda_oe_q itself marks whether the first fall (start
          // driving) or the second fall (end of slot) has been seen.
          ADDR_ACK, PTR_ACK, WDATA_ACK: if (scl_fall) begin
            if (!sda_oe_q) begin
              sda_oe_q <= ~I2C_ACK;
            end else begin
              sda_oe_q <= 1'b0;
              bitcnt_q <= '0;
              if (state_q == ADDR_ACK && rw_q) begin
                state_q  <= RDATA;
                shreg_q  <= {rd_byte[6:0], 1'b0};
                sda_oe_q <= ~rd_byte[7];
              end else if (state_q == ADDR_ACK) begin
                state_q <= PTR;
              end else begin
                state_q <= WDATA;
              end
            end
          end

          PTR: if (scl_rise) begin
            shreg_q <= shift_d;
            if (bitcnt_q == LAST_BIT) begin
              bitcnt_q <= '0;
              ptr_q    <= shift_d[AW-1:0];
              state_q  <= PTR_ACK;
            end else begin
              bitcnt_q <= bitcnt_q + 1'b1;
            end
          end

          WDATA: if (scl_rise) begin
            shreg_q <= shift_d;
            if (bitcnt_q == LAST_BIT) begin
              bitcnt_q   <= '0;
              wr_valid_q <= 1'b1;
              wr_addr_q  <= ptr_q;
              wr_data_q  <= shift_d;
              state_q    <= WDATA_ACK;
            end else begin
              bitcnt_q <= bitcnt_q + 1'b1;
            end
          end

          // Here bitcnt_q counts SCL rises; shreg_q holds the bits still to
          // be driven, already left-aligned.
          RDATA: if (scl_rise) begin
            bitcnt_q <= bitcnt_q + 1'b1;
          end else if (scl_fall) begin
            if (bitcnt_q == BYTE_BITS) begin
              sda_oe_q <= 1'b0;
              ptr_q    <= ptr_q + 1'b1;
              bitcnt_q <= '0;
              state_q  <= RDATA_ACK;
            end else begin
              shreg_q  <= {shreg_q[6:0], 1'b0};
              sda_oe_q <= ~shreg_q[7];
            end
          end

          // bitcnt_q != 0 records that the controller ACKed.
          RDATA_ACK: if (scl_rise) begin
            if (sda_s == I2C_NACK) state_q <= WAIT_STOP;
            else                   bitcnt_q <= BIT_CNT_W'(1);
          end else if (scl_fall && bitcnt_q != '0) begin
            bitcnt_q <= '0;
            state_q  <= RDATA;
            shreg_q  <= {rd_byte[6:0], 1'b0};
            sda_oe_q <= ~rd_byte[7];
          end

          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign bus.sda_oe    = sda_oe_q;
  assign bus.wr_valid  = wr_valid_q;
  assign bus.wr_addr   = wr_addr_q;
  assign bus.wr_data   = wr_data_q;
  assign bus.busy      = busy_q;
  assign bus.reg_rdata = regs_q[bus.reg_addr];

endmodule

// File: tb/tb_i2c_target_regfile.sv
// Self-checking bench for i2c_target_regfile: table-driven write
// transactions plus hand-written read, mismatch, abort and reset sequences.
module tb_i2c_target_regfile;
  import i2c_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic scl_m = 1'b1;
  logic sda_m = 1'b1;

  always #5 clk = ~clk;

  i2c_target_regfile_if #(.AW(4)) bus ();

  assign bus.scl_in = scl_m;
  assign bus.sda_in = sda_m & ~bus.sda_oe;

  i2c_target_regfile #(.TARGET_ADDR(7'h50), .NUM_REGS(16)) dut (
    .i2c_clk (clk),
    .rst     (rst),
    .bus     (bus)
  );

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  typedef struct { logic [3:0] a; logic [7:0] d; } wr_t;
  wr_t wlog[$];
  logic oe_seen = 1'b0;
  int ws_stage = 0;
  logic [7:0] ws_old, ws_new;

  always @(negedge clk) begin
    if (bus.sda_oe) oe_seen = 1'b1;
    if (bus.wr_valid) wlog.push_back('{bus.wr_addr, bus.wr_data});
    if (ws_stage == 2) begin
      chk("rd_after_wr", 32'(bus.reg_rdata), 32'(ws_new));
      ws_stage = 3;
    end else if (ws_stage == 1 && bus.wr_valid && bus.wr_addr == bus.reg_addr) begin
      chk("rd_before_wr", 32'(bus.reg_rdata), 32'(ws_old));
      ws_stage = 2;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic wait_clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_bit(input logic b, output logic s);
    wait_clks(4);
    sda_m = b;
    wait_clks(4);
    scl_m = 1'b1;
    wait_clks(4);
    s = bus.sda_in;
    wait_clks(4);
    scl_m = 1'b0;
  endtask

  task automatic i2c_start();
    sda_m = 1'b1;
    wait_clks(4);
    scl_m = 1'b1;
    wait_clks(4);
    sda_m = 1'b0;
    wait_clks(4);
    scl_m = 1'b0;
  endtask

  task automatic i2c_stop();
    sda_m = 1'b0;
    wait_clks(4);
    scl_m = 1'b1;
    wait_clks(4);
    sda_m = 1'b1;
    wait_clks(8);
  endtask

  task automatic send_byte(input logic [7:0] b, output logic ack);
    logic s;
    for (int i = 7; i >= 0; i--) send_bit(b[i], s);
    send_bit(1'b1, ack);
  endtask

  task automatic read_byte(input logic nack, output logic [7:0] d);
    logic s;
    for (int i = 7; i >= 0; i--) begin
      send_bit(1'b1, s);
      d[i] = s;
    end
    send_bit(nack, s);
  endtask

  typedef struct {
    logic [7:0] ptr;
    logic [7:0] d0;
    logic [7:0] d1;
    logic [3:0] i0;
    logic [3:0] i1;
  } vec_t;

  vec_t vecs[5];
  logic [7:0] model[16];

  initial begin
    logic a0, a1, a2, a3, s;
    logic [7:0] d;

    vecs[0] = '{8'h03, 8'h11, 8'h22, 4'd3,  4'd4};
    vecs[1] = '{8'h0F, 8'hAB, 8'hCD, 4'd15, 4'd0};
    vecs[2] = '{8'h13, 8'h77, 8'h88, 4'd3,  4'd4};
    vecs[3] = '{8'h05, 8'h5A, 8'h00, 4'd5,  4'd6};
    vecs[4] = '{8'h07, 8'hFF, 8'h99, 4'd7,  4'd8};
    for (int i = 0; i < 16; i++) model[i] = 8'h00;

    bus.reg_addr = 4'd0;
    wait_clks(3);
    chk("rst_sda_oe",   32'(bus.sda_oe),    32'd0);
    chk("rst_busy",     32'(bus.busy),      32'd0);
    chk("rst_wr_valid", 32'(bus.wr_valid),  32'd0);
    chk("rst_reg0",     32'(bus.reg_rdata), 32'd0);
    rst = 1'b1;
    wait_clks(4);

    // Table-driven write transactions.
    for (int v = 0; v < 5; v++) begin
      wlog.delete();
      bus.reg_addr = vecs[v].i0;
      if (v == 0) begin
        ws_old   = model[vecs[v].i0];
        ws_new   = vecs[v].d0;
        ws_stage = 1;
      end
      i2c_start();
      send_byte(8'hA0, a0);
      send_byte(vecs[v].ptr, a1);
      send_byte(vecs[v].d0, a2);
      send_byte(vecs[v].d1, a3);
      chk("wr_acks", 32'({a0, a1, a2, a3}), 32'd0);
      chk("busy_in_xfer", 32'(bus.busy), 32'd1);
      i2c_stop();
      wait_clks(6);
      chk("busy_after_stop", 32'(bus.busy), 32'd0);
      chk("wr_count", 32'(wlog.size()), 32'd2);
      if (wlog.size() >= 2) begin
        chk("wr0_addr", 32'(wlog[0].a), 32'(vecs[v].i0));
        chk("wr0_data", 32'(wlog[0].d), 32'(vecs[v].d0));
        chk("wr1_addr", 32'(wlog[1].a), 32'(vecs[v].i1));
        chk("wr1_data", 32'(wlog[1].d), 32'(vecs[v].d1));
      end
      model[vecs[v].i0] = vecs[v].d0;
      model[vecs[v].i1] = vecs[v].d1;
      bus.reg_addr = vecs[v].i0;
      wait_clks(1);
      chk("rdata_i0", 32'(bus.reg_rdata), 32'(vecs[v].d0));
      bus.reg_addr = vecs[v].i1;
      wait_clks(1);
      chk("rdata_i1", 32'(bus.reg_rdata), 32'(vecs[v].d1));
    end
    chk("rd_window_seen", 32'(ws_stage), 32'd3);

    // Pointer set, repeated START, 3-byte read ACK/ACK/NACK.
    wlog.delete();
    i2c_start();
    send_byte(8'hA0, a0);
    send_byte(8'h05, a1);
    i2c_start();
    send_byte(8'hA1, a2);
    chk("rd_acks", 32'({a0, a1, a2}), 32'd0);
    chk("rd_busy", 32'(bus.busy), 32'd1);
    read_byte(1'b0, d);
    chk("rd_byte0", 32'(d), 32'h5A);
    read_byte(1'b0, d);
    chk("rd_byte1", 32'(d), 32'h00);
    read_byte(1'b1, d);
    chk("rd_byte2", 32'(d), 32'hFF);
    wait_clks(6);
    chk("rd_released", 32'(bus.sda_oe), 32'd0);
    chk("rd_wait_stop", 32'(dut.state_q), 32'(WAIT_STOP));
    chk("rd_busy_pre_stop", 32'(bus.busy), 32'd1);
    i2c_stop();
    wait_clks(6);
    chk("rd_busy_stop", 32'(bus.busy), 32'd0);
    chk("rd_no_writes", 32'(wlog.size()), 32'd0);

    // Address 0x51: no ACK, SDA never driven.
    oe_seen = 1'b0;
    i2c_start();
    send_byte(8'hA2, a0);
    chk("mis_nack", 32'(a0), 32'd1);
    chk("mis_no_oe", 32'(oe_seen), 32'd0);
    chk("mis_busy", 32'(bus.busy), 32'd0);
    i2c_stop();
    wait_clks(4);
    chk("mis_idle", 32'(dut.state_q), 32'(IDLE));

    // STOP after 4 data bits: nothing written.
    wlog.delete();
    bus.reg_addr = 4'd2;
    i2c_start();
    send_byte(8'hA0, a0);
    send_byte(8'h02, a1);
    send_bit(1'b1, s);
    send_bit(1'b0, s);
    send_bit(1'b1, s);
    send_bit(1'b0, s);
    i2c_stop();
    wait_clks(4);
    chk("abort_no_wr", 32'(wlog.size()), 32'd0);
    chk("abort_reg2", 32'(bus.reg_rdata), 32'(model[2]));
    chk("abort_idle", 32'(dut.state_q), 32'(IDLE));
    chk("abort_busy", 32'(bus.busy), 32'd0);

    // Reset while driving a 0 read bit (reg 6 = 0x00).
    bus.reg_addr = 4'd5;
    i2c_start();
    send_byte(8'hA0, a0);
    send_byte(8'h06, a1);
    i2c_start();
    send_byte(8'hA1, a2);
    wait_clks(6);
    chk("rr_driving", 32'(bus.sda_oe), 32'd1);
    rst = 1'b0;
    #1;
    chk("rr_oe_async", 32'(bus.sda_oe), 32'd0);
    chk("rr_busy", 32'(bus.busy), 32'd0);
    chk("rr_wr_valid", 32'(bus.wr_valid), 32'd0);
    chk("rr_wr_addr", 32'(bus.wr_addr), 32'd0);
    chk("rr_wr_data", 32'(bus.wr_data), 32'd0);
    chk("rr_reg5", 32'(bus.reg_rdata), 32'd0);
    chk("rr_state", 32'(dut.state_q), 32'(IDLE));
    wait_clks(3);
    rst = 1'b1;
    oe_seen = 1'b0;
    send_byte(8'hA0, a0);
    chk("rr_ignore_ack", 32'(a0), 32'd1);
    chk("rr_ignore_oe", 32'(oe_seen), 32'd0);
    chk("rr_ignore_idle", 32'(dut.state_q), 32'(IDLE));
    i2c_stop();
    wait_clks(4);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
